// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: hazard/branch/halt requests in,
// PC/IF-ID control, debug state and fetch counter out.
interface fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             hazardStall;
    logic             branchReq;
    logic [31:0]      branchTarget;
    logic             haltReq;
    logic             pcEnb;
    logic             branchTaken;
    logic [31:0]      branchAddress;
    logic             ifidEnb;
    logic             flush;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] fetchCount;

    modport master (
        input  hazardStall,
        input  branchReq,
        input  branchTarget,
        input  haltReq,
        output pcEnb,
        output branchTaken,
        output branchAddress,
        output ifidEnb,
        output flush,
        output halted,
        output state,
        output fetchCount
    );

    modport slave (
        output hazardStall,
        output branchReq,
        output branchTarget,
        output haltReq,
        input  pcEnb,
        input  branchTaken,
        input  branchAddress,
        input  ifidEnb,
        input  flush,
        input  halted,
        input  state,
        input  fetchCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: boot delay, branch redirect with
// flush window, hazard stall and halt, plus fetch counter.
module fetch_sequencer #(
    parameter int BOOT_CYCLES  = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic                clk,
    input logic                rst,
    fetch_sequencer_if.master  bus
);
    localparam logic [1:0] BOOT     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;
    localparam logic [1:0] HALT     = 2'd3;

    localparam int BW = $clog2(BOOT_CYCLES) + 1;
    localparam int FW = $clog2(FLUSH_CYCLES) + 1;

    localparam logic [BW-1:0] BOOT_LAST  = BW'(BOOT_CYCLES - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    logic [1:0]       curState;
    logic [1:0]       nextState;
    logic [BW-1:0]    bootCnt;
    logic [BW-1:0]    nextBoot;
    logic [FW-1:0]    flushCnt;
    logic [FW-1:0]    nextFlush;
    logic [CNT_W-1:0] fetchCnt;
    logic             pcEn;
    logic             taken;
    logic             ifidEn;
    logic             flushOn;
    logic             haltOn;

    // Output decode and next-state selection by fixed priority
    always_comb begin
        nextState = curState;
        nextBoot  = bootCnt;
        nextFlush = flushCnt;
        pcEn      = 1'b0;
        taken     = 1'b0;
        ifidEn    = 1'b0;
        flushOn   = 1'b0;
        haltOn    = 1'b0;
        case (curState)
            BOOT: begin
                if (bootCnt == BOOT_LAST) begin
                    nextState = RUN;
                    nextBoot  = '0;
                end else begin
                    nextBoot = bootCnt + 1'b1;
                end
            end
            RUN: begin
                if (bus.branchReq) begin
                    pcEn    = 1'b1;
                    taken   = 1'b1;
                    ifidEn  = 1'b1;
                    flushOn = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        nextState = REDIRECT;
                        nextFlush = FW'(1);
                    end
                end else if (bus.haltReq) begin
                    nextState = HALT;
                end else if (!bus.hazardStall) begin
                    pcEn   = 1'b1;
                    ifidEn = 1'b1;
                end
            end
            REDIRECT: begin
                pcEn    = 1'b1;
                ifidEn  = 1'b1;
                flushOn = 1'b1;
                if (flushCnt == FLUSH_LAST) begin
                    nextState = RUN;
                    nextFlush = '0;
                end else begin
                    nextFlush = flushCnt + 1'b1;
                end
            end
            HALT: begin
                haltOn = 1'b1;
                if (!bus.haltReq) begin
                    nextState = RUN;
                end
            end
            default: begin
                nextState = BOOT;
                nextBoot  = '0;
                nextFlush = '0;
            end
        endcase
    end

    // State and sub-counters, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curState <= BOOT;
            bootCnt  <= '0;
            flushCnt <= '0;
        end else begin
            curState <= nextState;
            bootCnt  <= nextBoot;
            flushCnt <= nextFlush;
        end
    end

    // Free-running fetch counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchCnt <= '0;
        end else if (pcEn) begin
            fetchCnt <= fetchCnt + 1'b1;
        end
    end

    assign bus.pcEnb         = pcEn;
    assign bus.branchTaken   = taken;
    assign bus.branchAddress = taken ? bus.branchTarget : 32'd0;
    assign bus.ifidEnb       = ifidEn;
    assign bus.flush         = flushOn;
    assign bus.halted        = haltOn;
    assign bus.state         = curState;
    assign bus.fetchCount    = fetchCnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random
// traffic, checked every cycle against a behavioural model.
module tb_fetch_sequencer;
    localparam int CW = 6;
    localparam int BC = 4;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int mMode;
    int mBootLeft;
    int mFlushLeft;
    int mCount;

    fetch_sequencer_if #(.CNT_W(CW)) bus ();

    fetch_sequencer #(
        .BOOT_CYCLES (BC),
        .FLUSH_CYCLES(FC),
        .CNT_W       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mMode      = 0;
        mBootLeft  = BC;
        mFlushLeft = 0;
        mCount     = 0;
    endtask

    task automatic setIn(logic hz, logic br,
                         logic [31:0] tg, logic ht);
        bus.hazardStall  = hz;
        bus.branchReq    = br;
        bus.branchTarget = tg;
        bus.haltReq      = ht;
    endtask

    // One clock: check at negedge, advance model at posedge
    task automatic cycle();
        logic ePc, eBt, eIf, eFl, eHt;
        logic [31:0] eAddr;
        @(negedge clk);
        ePc = 0; eBt = 0; eIf = 0; eFl = 0; eHt = 0;
        if (mMode == 1) begin
            if (bus.branchReq) begin
                ePc = 1; eBt = 1; eIf = 1; eFl = 1;
            end else if (!bus.haltReq && !bus.hazardStall) begin
                ePc = 1; eIf = 1;
            end
        end else if (mMode == 2) begin
            ePc = 1; eIf = 1; eFl = 1;
        end else if (mMode == 3) begin
            eHt = 1;
        end
        eAddr = eBt ? bus.branchTarget : 32'd0;
        chk("state", 32'(bus.state), 32'(mMode));
        chk("pcEnb", 32'(bus.pcEnb), 32'(ePc));
        chk("branchTaken", 32'(bus.branchTaken), 32'(eBt));
        chk("branchAddress", bus.branchAddress, eAddr);
        chk("ifidEnb", 32'(bus.ifidEnb), 32'(eIf));
        chk("flush", 32'(bus.flush), 32'(eFl));
        chk("halted", 32'(bus.halted), 32'(eHt));
        chk("fetchCount", 32'(bus.fetchCount), 32'(mCount));
        @(posedge clk);
        if (ePc) mCount = (mCount + 1) % (1 << CW);
        case (mMode)
            0: begin
                mBootLeft--;
                if (mBootLeft == 0) mMode = 1;
            end
            1: begin
                if (bus.branchReq) begin
                    mFlushLeft = FC - 1;
                    if (mFlushLeft > 0) mMode = 2;
                end else if (bus.haltReq) begin
                    mMode = 3;
                end
            end
            2: begin
                mFlushLeft--;
                if (mFlushLeft == 0) mMode = 1;
            end
            default: begin
                if (!bus.haltReq) mMode = 1;
            end
        endcase
        #1;
    endtask

    initial begin
        logic ht;
        setIn(0, 0, 32'd0, 0);
        modelReset();
        #2;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pcEnb", 32'(bus.pcEnb), 32'd0);
        chk("rst_count", 32'(bus.fetchCount), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // boot window then three fetch cycles
        repeat (BC + 3) cycle();
        chk("count_after_3", 32'(bus.fetchCount), 32'd3);

        // taken branch and its flush window
        setIn(0, 1, 32'h0000_0040, 0);
        cycle();
        setIn(0, 0, 32'h0000_0040, 0);
        cycle();
        cycle();

        // branch beats hazard stall
        setIn(1, 1, 32'h0000_1234, 0);
        cycle();
        setIn(0, 0, 32'd0, 0);
        repeat (2) cycle();

        // three stall cycles
        setIn(1, 0, 32'd0, 0);
        repeat (3) cycle();
        setIn(0, 0, 32'd0, 0);
        repeat (2) cycle();

        // halt with a branch pulse while halted
        setIn(0, 0, 32'd0, 1);
        repeat (2) cycle();
        setIn(0, 1, 32'h0000_0080, 1);
        cycle();
        setIn(0, 0, 32'd0, 1);
        repeat (2) cycle();
        setIn(0, 0, 32'd0, 0);
        repeat (3) cycle();

        // random traffic; counter wraps several times
        ht = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) ht = ~ht;
            setIn(logic'($urandom_range(3) == 0),
                  logic'($urandom_range(5) == 0),
                  $urandom, ht);
            cycle();
        end

        // async reset in the middle of a redirect
        setIn(0, 0, 32'd0, 0);
        repeat (8) cycle();
        setIn(0, 1, 32'h0000_0100, 0);
        cycle();
        setIn(0, 0, 32'd0, 0);
        @(negedge clk);
        chk("pre_rst_state", 32'(bus.state), 32'(mMode));
        chk("pre_rst_flush", 32'(bus.flush), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_state", 32'(bus.state), 32'd0);
        chk("async_flush", 32'(bus.flush), 32'd0);
        chk("async_pcEnb", 32'(bus.pcEnb), 32'd0);
        chk("async_count", 32'(bus.fetchCount), 32'd0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (BC + 4) cycle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
